// File: rtl/pwl_agc_pkg.sv
// pwl_agc_pkg: shared FSM states and real-valued helpers for the PWL AGC loop
package pwl_agc_pkg;
    timeunit 1ns;
    timeprecision 1ps;

    typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DECIDE} state_t;

    // PWL time origins are in seconds; simulation time is in ns
    localparam real T_SCALE = 1.0e-9;

    function automatic real code2gain(input int unsigned code, input real gmin, input real gstep);
        return gmin + gstep * real'(code);
    endfunction

    function automatic real pwl_eval(input real a, input real b, input real t0, input real t);
        return a + b * (t - t0);
    endfunction

    function automatic real rabs(input real x);
        return (x < 0.0) ? -x : x;
    endfunction
endpackage

// File: rtl/pwl_abs_accum.sv
// pwl_abs_accum: samples |pwl| on each run edge and sums N_AVG samples.
// done is combinational and marks the edge that takes the final sample.
module pwl_abs_accum
    import pwl_agc_pkg::*;
#(
    parameter int N_AVG = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  real  in_a,
    input  real  in_b,
    input  real  in_t0,
    output real  sum,
    output logic done
);
    timeunit 1ns;
    timeprecision 1ps;

    localparam int CW = $clog2(N_AVG + 1);

    logic [CW-1:0] r_cnt;
    real           r_sum;

    assign done = run && (r_cnt == CW'(N_AVG - 1));
    assign sum  = r_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sum <= 0.0;
            r_cnt <= '0;
        end else if (clear) begin
            r_sum <= 0.0;
            r_cnt <= '0;
        end else if (run) begin
            r_sum <= r_sum + rabs(pwl_eval(in_a, in_b, in_t0, $realtime * T_SCALE));
            r_cnt <= done ? '0 : r_cnt + CW'(1);
        end
    end
endmodule

// File: rtl/pwl_agc_ctrl.sv
// pwl_agc_ctrl: windowed-magnitude AGC loop stepping a saturating gain code
// toward a real target amplitude; reports lock and saturation.
module pwl_agc_ctrl
    import pwl_agc_pkg::*;
#(
    parameter int  CODE_W     = 6,
    parameter int  RESET_CODE = 32,
    parameter real GAIN_MIN   = 0.25,
    parameter real GAIN_STEP  = 0.05,
    parameter int  N_AVG      = 16,
    parameter int  SETTLE_CYC = 8,
    parameter real DEADBAND   = 0.02,
    parameter int  LOCK_CNT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  real               target,
    input  real               in_a,
    input  real               in_b,
    input  real               in_t0,
    output real               gain,
    output logic [CODE_W-1:0] gain_code,
    output logic              locked,
    output logic              sat
);
    timeunit 1ns;
    timeprecision 1ps;

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [CODE_W-1:0] CODE_MAX = {CODE_W{1'b1}};

    state_t            r_state, w_next;
    logic [SW-1:0]     r_settle;
    logic [LW-1:0]     r_inb;
    logic [CODE_W-1:0] r_code, w_code_nxt;
    logic              r_locked, r_sat;
    logic              w_clear, w_run, w_done, w_settle_end, w_hi, w_lo, w_decide;
    real               w_sum, w_mean;

    pwl_abs_accum #(.N_AVG(N_AVG)) u_acc (
        .clk   (clk),
        .reset (reset),
        .clear (w_clear),
        .run   (w_run),
        .in_a  (in_a),
        .in_b  (in_b),
        .in_t0 (in_t0),
        .sum   (w_sum),
        .done  (w_done)
    );

    assign w_settle_end = r_settle == SW'(SETTLE_CYC - 1);
    assign w_run        = en && r_state == ACCUM;
    assign w_clear      = !en || r_state == IDLE || r_state == DECIDE;
    assign w_decide     = en && r_state == DECIDE;

    always_comb begin
        w_mean     = w_sum / real'(N_AVG);
        w_hi       = w_mean > target + DEADBAND;
        w_lo       = w_mean < target - DEADBAND;
        w_code_nxt = (w_hi && r_code != '0) ? r_code - 1'b1 :
                     (w_lo && r_code != CODE_MAX) ? r_code + 1'b1 : r_code;
        w_next     = IDLE;
        case (r_state)
            IDLE:    w_next = SETTLE;
            SETTLE:  w_next = w_settle_end ? ACCUM : SETTLE;
            ACCUM:   w_next = w_done ? DECIDE : ACCUM;
            DECIDE:  w_next = (w_code_nxt != r_code) ? SETTLE : ACCUM;
            default: w_next = IDLE;
        endcase
        if (!en) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_settle <= '0;
        end else begin
            r_state  <= w_next;
            r_settle <= (en && r_state == SETTLE && !w_settle_end) ? r_settle + SW'(1) : '0;
        end
    end

    // In-band counter saturates so lock persists through a long in-band run
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code   <= CODE_W'(RESET_CODE);
            r_inb    <= '0;
            r_locked <= 1'b0;
            r_sat    <= 1'b0;
        end else if (w_decide) begin
            r_code   <= w_code_nxt;
            r_inb    <= (w_hi || w_lo) ? '0 : (r_inb == LW'(LOCK_CNT)) ? r_inb : r_inb + LW'(1);
            r_locked <= !(w_hi || w_lo) && r_inb >= LW'(LOCK_CNT - 1);
            r_sat    <= (w_hi && r_code == '0) || (w_lo && r_code == CODE_MAX);
        end
    end

    assign gain      = code2gain(32'(r_code), GAIN_MIN, GAIN_STEP);
    assign gain_code = r_code;
    assign locked    = r_locked;
    assign sat       = r_sat;
endmodule

// File: tb/tb_pwl_agc_ctrl.sv
// tb_pwl_agc_ctrl: randomized scoreboard bench; a window-level reference model
// queues expected outputs each edge and a negedge monitor compares them.
module tb_pwl_agc_ctrl;
    timeunit 1ns;
    timeprecision 1ps;

    localparam int  SETTLE = 8;
    localparam int  NAVG   = 16;
    localparam int  LOCKN  = 4;
    localparam int  RCODE  = 32;
    localparam real GMIN   = 0.25;
    localparam real GSTEP  = 0.05;
    localparam real DB     = 0.02;

    logic       clk = 0, reset = 1, en = 0;
    real        target = 0.5, in_a = 0.0, in_b = 0.0, in_t0 = 0.0;
    real        gain;
    logic [5:0] gain_code;
    logic       locked, sat;

    int  checks = 0, errors = 0;
    bit  closed = 0;
    real loop_k = 0.4;

    typedef struct packed {
        logic [7:0] code;
        logic       lk;
        logic       st;
    } exp_t;
    exp_t sb[$];

    int  m_code = RCODE, m_inb = 0, m_wait = -1;
    bit  m_locked = 0, m_sat = 0;
    real m_win[$];

    pwl_agc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .target    (target),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_t0     (in_t0),
        .gain      (gain),
        .gain_code (gain_code),
        .locked    (locked),
        .sat       (sat)
    );

    always #0.5 clk = ~clk;

    function automatic real mag(input real x);
        return (x < 0.0) ? -x : x;
    endfunction

    task automatic model_decide();
        real s, mean;
        int  want, nc;
        bit  over, under;
        s = 0.0;
        foreach (m_win[i]) s = s + m_win[i];
        mean  = s / real'(NAVG);
        over  = mean > target + DB;
        under = mean < target - DB;
        want  = over ? m_code - 1 : under ? m_code + 1 : m_code;
        nc    = (want < 0) ? 0 : (want > 63) ? 63 : want;
        m_sat = (want != nc);
        if (over || under) begin
            m_inb    = 0;
            m_locked = 0;
        end else begin
            m_inb    = (m_inb + 1 > LOCKN) ? LOCKN : m_inb + 1;
            m_locked = (m_inb >= LOCKN);
        end
        m_wait = (nc != m_code) ? SETTLE : 0;
        m_code = nc;
        m_win.delete();
    endtask

    // Window-level model: an idle edge arms a settle, then samples are
    // gathered until a full window exists, and the following edge decides.
    always @(posedge clk) begin
        if (reset) begin
            m_code = RCODE; m_inb = 0; m_locked = 0; m_sat = 0; m_wait = -1;
            m_win.delete();
        end else if (!en) begin
            m_wait = -1;
            m_win.delete();
        end else if (m_wait < 0) m_wait = SETTLE;
        else if (m_win.size() == NAVG) model_decide();
        else if (m_wait > 0) m_wait--;
        else m_win.push_back(mag(in_a + in_b * ($realtime * 1.0e-9 - in_t0)));
        sb.push_back('{8'(m_code), m_locked, m_sat});
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_gain(input real act, input int code);
        real e;
        e = GMIN + GSTEP * real'(code);
        checks++;
        if (mag(act - e) > 1.0e-9) begin
            errors++;
            $display("FAIL gain t=%0t got %f expected %f", $time, act, e);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("gain_code", int'(gain_code), int'(e.code));
            chk("locked", int'(locked), int'(e.lk));
            chk("sat", int'(sat), int'(e.st));
            chk_gain(gain, int'(e.code));
        end
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (closed) in_a = gain * loop_k;
        end
    endtask

    task automatic async_reset_check();
        @(negedge clk);
        #0.1 reset = 1;
        #0.1;
        chk("async_code", int'(gain_code), RCODE);
        chk("async_locked", int'(locked), 0);
        chk("async_sat", int'(sat), 0);
        chk_gain(gain, RCODE);
        cyc(2);
        reset = 0;
    endtask

    initial begin
        cyc(5);
        reset = 0; en = 1; target = 0.5; in_a = 1.0;
        cyc(110);
        // en drop during the 7th ACCUM cycle, then resume
        async_reset_check();
        cyc(1 + SETTLE + 6);
        en = 0;
        cyc(3);
        en = 1;
        cyc(60);
        // async reset part-way through ACCUM
        cyc(1 + SETTLE + 4);
        async_reset_check();
        closed = 1; loop_k = 0.4; target = 0.5;
        cyc(700);
        closed = 0; in_a = 0.0; in_b = 0.0;
        cyc(1300);
        in_b = 1.0e9; in_t0 = $realtime * 1.0e-9; target = 8.0;
        cyc(120);
        in_b = 0.0;
        for (int s = 0; s < 20; s++) begin
            en     = ($urandom_range(0, 9) != 0);
            target = real'($urandom_range(0, 2000)) / 1000.0;
            closed = ($urandom_range(0, 2) == 0);
            loop_k = real'($urandom_range(100, 1000)) / 1000.0;
            in_a   = (real'($urandom_range(0, 4000)) - 2000.0) / 1000.0;
            in_b   = (real'($urandom_range(0, 2000)) - 1000.0) * 1.0e3;
            in_t0  = $realtime * 1.0e-9;
            if ($urandom_range(0, 4) == 0) async_reset_check();
            cyc($urandom_range(10, 250));
        end
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
